// File: rtl/tpu_uart_pkg.sv
// Shared definitions for the TPU UART command controller: opcodes, FSM state
// encodings and payload/response lengths.
package tpu_uart_pkg;

  localparam logic [7:0] OP_WRITE_WEIGHTS = 8'h01;
  localparam logic [7:0] OP_WRITE_ACT     = 8'h02;
  localparam logic [7:0] OP_RUN           = 8'h03;
  localparam logic [7:0] OP_STATUS        = 8'h04;
  localparam logic [7:0] OP_READ_ACC0     = 8'h05;
  localparam logic [7:0] OP_READ_ACC1     = 8'h06;
  localparam logic [7:0] OP_CLEAR_WEIGHTS = 8'h07;

  localparam int unsigned WEIGHT_PAYLOAD_LEN = 4;
  localparam int unsigned ACT_PAYLOAD_LEN    = 2;
  localparam int unsigned STATUS_RESP_LEN    = 2;
  localparam int unsigned ACC_RESP_LEN       = 4;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_GET_PAYLOAD = 4'd1,
    ST_EXECUTE     = 4'd2,
    ST_SEND        = 4'd3,
    ST_WAIT_TX     = 4'd4
  } ctrl_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Index of the final payload byte for commands that carry a payload.
  function automatic logic [2:0] payload_last(input logic [7:0] op);
    return (op == OP_WRITE_WEIGHTS) ? 3'(WEIGHT_PAYLOAD_LEN - 1) : 3'(ACT_PAYLOAD_LEN - 1);
  endfunction

  // Index of the final response byte for commands that reply.
  function automatic logic [1:0] resp_last(input logic [7:0] op);
    return (op == OP_STATUS) ? 2'(STATUS_RESP_LEN - 1) : 2'(ACC_RESP_LEN - 1);
  endfunction

endpackage

// File: rtl/uart_phy.sv
// 8N1 UART receiver and transmitter sharing one bit-period parameter.
// RX oversamples with a per-bit counter and samples at mid-bit.
module uart_phy
  import tpu_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  output logic       o_tx,
  input  logic       i_tx_valid,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_ready,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_data
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             r_rx_meta;
  logic             r_rx_sync;
  logic             r_rx_prev;
  rx_state_e        r_rx_state;
  rx_state_e        w_rx_state_next;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [2:0]       r_rx_bit_idx;
  logic [7:0]       r_rx_shift;
  logic             r_rx_valid;
  logic [7:0]       r_rx_data;
  logic             w_rx_fall;
  logic             w_rx_half_tick;
  logic             w_rx_bit_tick;

  // Sync flops reset low, so a falling edge needs the line to be seen high first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b0;
      r_rx_sync <= 1'b0;
      r_rx_prev <= 1'b0;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_rx_fall      = r_rx_prev & ~r_rx_sync;
  assign w_rx_half_tick = (r_rx_cnt == HALF_LAST);
  assign w_rx_bit_tick  = (r_rx_cnt == BIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state <= RX_IDLE;
    end else begin
      r_rx_state <= w_rx_state_next;
    end
  end

  always_comb begin
    w_rx_state_next = r_rx_state;
    unique case (r_rx_state)
      RX_IDLE:  if (w_rx_fall) w_rx_state_next = RX_START;
      RX_START: if (w_rx_half_tick) w_rx_state_next = r_rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_bit_tick && (r_rx_bit_idx == 3'd7)) w_rx_state_next = RX_STOP;
      RX_STOP:  if (w_rx_bit_tick) w_rx_state_next = RX_IDLE;
      default:  w_rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_cnt     <= '0;
      r_rx_bit_idx <= '0;
      r_rx_shift   <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_data    <= '0;
    end else begin
      r_rx_valid <= 1'b0;
      if ((r_rx_state == RX_IDLE) || (r_rx_state != w_rx_state_next) || w_rx_bit_tick) begin
        r_rx_cnt <= '0;
      end else begin
        r_rx_cnt <= r_rx_cnt + 1'b1;
      end
      if (r_rx_state == RX_IDLE) begin
        r_rx_bit_idx <= '0;
      end
      if ((r_rx_state == RX_DATA) && w_rx_bit_tick) begin
        r_rx_shift   <= {r_rx_sync, r_rx_shift[7:1]};
        r_rx_bit_idx <= r_rx_bit_idx + 3'd1;
      end
      if ((r_rx_state == RX_STOP) && w_rx_bit_tick && r_rx_sync) begin
        r_rx_valid <= 1'b1;
        r_rx_data  <= r_rx_shift;
      end
    end
  end

  assign o_rx_valid = r_rx_valid;
  assign o_rx_data  = r_rx_data;

  logic             r_tx_busy;
  logic             r_tx_line;
  logic [8:0]       r_tx_shift;
  logic [3:0]       r_tx_bit_idx;
  logic [CNT_W-1:0] r_tx_cnt;

  // Slot 0 is the start bit, slots 1..8 data, slot 9 the stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_busy    <= 1'b0;
      r_tx_line    <= 1'b1;
      r_tx_shift   <= '0;
      r_tx_bit_idx <= '0;
      r_tx_cnt     <= '0;
    end else if (!r_tx_busy) begin
      if (i_tx_valid) begin
        r_tx_busy    <= 1'b1;
        r_tx_line    <= 1'b0;
        r_tx_shift   <= {1'b1, i_tx_data};
        r_tx_bit_idx <= '0;
        r_tx_cnt     <= '0;
      end
    end else if (r_tx_cnt == BIT_LAST) begin
      r_tx_cnt <= '0;
      if (r_tx_bit_idx == 4'd9) begin
        r_tx_busy <= 1'b0;
      end else begin
        r_tx_line    <= r_tx_shift[0];
        r_tx_shift   <= {1'b1, r_tx_shift[8:1]};
        r_tx_bit_idx <= r_tx_bit_idx + 4'd1;
      end
    end else begin
      r_tx_cnt <= r_tx_cnt + 1'b1;
    end
  end

  assign o_tx       = r_tx_line;
  assign o_tx_ready = ~r_tx_busy;

endmodule

// File: rtl/tpu_uart_controller.sv
// UART command front end for the TPU: decodes opcodes, loads weights and
// activations, starts the MLP and returns status/accumulators. Debug mirrors: UART_CTRL_DEBUG_EN.
module tpu_uart_controller
  import tpu_uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               uart_rx,
  output logic               uart_tx,
  output logic               wf_push_col0,
  output logic               wf_push_col1,
  output logic [7:0]         wf_data_in,
  output logic               wf_reset,
  output logic               init_act_valid,
  output logic [15:0]        init_act_data,
  output logic               start_mlp,
  output logic               weights_ready,
  input  logic [3:0]         mlp_state,
  input  logic [4:0]         mlp_cycle_cnt,
  input  logic signed [31:0] mlp_acc0,
  input  logic signed [31:0] mlp_acc1,
  output logic [3:0]         dbg_state,
  output logic [7:0]         dbg_cmd_reg,
  output logic [2:0]         dbg_byte_count,
  output logic [1:0]         dbg_resp_byte_idx,
  output logic               dbg_tx_valid,
  output logic               dbg_tx_ready,
  output logic               dbg_rx_valid,
  output logic [7:0]         dbg_rx_data,
  output logic               dbg_weights_ready,
  output logic               dbg_start_mlp
);

  localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;

  logic        w_rx_valid;
  logic [7:0]  w_rx_data;
  logic        w_tx_valid;
  logic [7:0]  w_tx_data;
  logic        w_tx_ready;
  logic        w_start_mlp;
  logic        w_wf_reset;

  ctrl_state_e r_state;
  ctrl_state_e w_state_next;
  logic [7:0]  r_cmd_reg;
  logic [2:0]  r_byte_count;
  logic [1:0]  r_resp_byte_idx;
  logic [31:0] r_resp_word;
  logic [7:0]  r_act_lo;
  logic [7:0]  r_wf_data;
  logic        r_push_col0;
  logic        r_push_col1;
  logic        r_act_valid;
  logic [15:0] r_act_data;
  logic        r_weights_ready;

  uart_phy #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_phy (
    .clk        (clk),
    .rst_n      (rst),
    .i_rx       (uart_rx),
    .o_tx       (uart_tx),
    .i_tx_valid (w_tx_valid),
    .i_tx_data  (w_tx_data),
    .o_tx_ready (w_tx_ready),
    .o_rx_valid (w_rx_valid),
    .o_rx_data  (w_rx_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_tx_valid   = 1'b0;
    w_start_mlp  = 1'b0;
    w_wf_reset   = 1'b0;
    unique case (r_resp_byte_idx)
      2'd0:    w_tx_data = r_resp_word[7:0];
      2'd1:    w_tx_data = r_resp_word[15:8];
      2'd2:    w_tx_data = r_resp_word[23:16];
      default: w_tx_data = r_resp_word[31:24];
    endcase
    unique case (r_state)
      ST_IDLE: begin
        if (w_rx_valid) begin
          case (w_rx_data)
            OP_WRITE_WEIGHTS, OP_WRITE_ACT:          w_state_next = ST_GET_PAYLOAD;
            OP_RUN, OP_CLEAR_WEIGHTS:                w_state_next = ST_EXECUTE;
            OP_STATUS, OP_READ_ACC0, OP_READ_ACC1:   w_state_next = ST_SEND;
            default:                                 w_state_next = ST_IDLE;
          endcase
        end
      end
      ST_GET_PAYLOAD: begin
        if (w_rx_valid && (r_byte_count == payload_last(r_cmd_reg))) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_EXECUTE: begin
        w_start_mlp  = (r_cmd_reg == OP_RUN);
        w_wf_reset   = (r_cmd_reg == OP_CLEAR_WEIGHTS);
        w_state_next = ST_IDLE;
      end
      ST_SEND: begin
        w_tx_valid = 1'b1;
        if (w_tx_ready) w_state_next = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (w_tx_ready) begin
          w_state_next = (r_resp_byte_idx == resp_last(r_cmd_reg)) ? ST_IDLE : ST_SEND;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cmd_reg       <= '0;
      r_byte_count    <= '0;
      r_resp_byte_idx <= '0;
      r_resp_word     <= '0;
      r_act_lo        <= '0;
      r_wf_data       <= '0;
      r_push_col0     <= 1'b0;
      r_push_col1     <= 1'b0;
      r_act_valid     <= 1'b0;
      r_act_data      <= '0;
      r_weights_ready <= 1'b0;
    end else begin
      r_push_col0 <= 1'b0;
      r_push_col1 <= 1'b0;
      r_act_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_rx_valid) begin
            r_cmd_reg       <= w_rx_data;
            r_byte_count    <= '0;
            r_resp_byte_idx <= '0;
            // Response value is frozen here so a moving accumulator cannot tear.
            case (w_rx_data)
              OP_STATUS:    r_resp_word <= {16'h0000, 3'b000, mlp_cycle_cnt, 4'h0, mlp_state};
              OP_READ_ACC0: r_resp_word <= mlp_acc0;
              OP_READ_ACC1: r_resp_word <= mlp_acc1;
              default:      r_resp_word <= r_resp_word;
            endcase
          end
        end
        ST_GET_PAYLOAD: begin
          if (w_rx_valid) begin
            r_byte_count <= r_byte_count + 3'd1;
            if (r_cmd_reg == OP_WRITE_WEIGHTS) begin
              r_wf_data   <= w_rx_data;
              r_push_col0 <= (r_byte_count < 3'd2);
              r_push_col1 <= (r_byte_count >= 3'd2);
              if (r_byte_count == payload_last(r_cmd_reg)) r_weights_ready <= 1'b1;
            end else if (r_byte_count == 3'd0) begin
              r_act_lo <= w_rx_data;
            end else begin
              r_act_data  <= {w_rx_data, r_act_lo};
              r_act_valid <= 1'b1;
            end
          end
        end
        ST_EXECUTE: begin
          if (r_cmd_reg == OP_CLEAR_WEIGHTS) r_weights_ready <= 1'b0;
        end
        ST_WAIT_TX: begin
          if (w_tx_ready && (r_resp_byte_idx != resp_last(r_cmd_reg))) begin
            r_resp_byte_idx <= r_resp_byte_idx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign wf_push_col0   = r_push_col0;
  assign wf_push_col1   = r_push_col1;
  assign wf_data_in     = r_wf_data;
  assign wf_reset       = w_wf_reset;
  assign init_act_valid = r_act_valid;
  assign init_act_data  = r_act_data;
  assign start_mlp      = w_start_mlp;
  assign weights_ready  = r_weights_ready;

`ifdef UART_CTRL_DEBUG_EN
  assign dbg_state         = r_state;
  assign dbg_cmd_reg       = r_cmd_reg;
  assign dbg_byte_count    = r_byte_count;
  assign dbg_resp_byte_idx = r_resp_byte_idx;
  assign dbg_tx_valid      = w_tx_valid;
  assign dbg_tx_ready      = w_tx_ready;
  assign dbg_rx_valid      = w_rx_valid;
  assign dbg_rx_data       = w_rx_data;
  assign dbg_weights_ready = r_weights_ready;
  assign dbg_start_mlp     = w_start_mlp;
`else
  assign dbg_state         = '0;
  assign dbg_cmd_reg       = '0;
  assign dbg_byte_count    = '0;
  assign dbg_resp_byte_idx = '0;
  assign dbg_tx_valid      = 1'b0;
  assign dbg_tx_ready      = 1'b0;
  assign dbg_rx_valid      = 1'b0;
  assign dbg_rx_data       = '0;
  assign dbg_weights_ready = 1'b0;
  assign dbg_start_mlp     = 1'b0;
`endif

endmodule

// File: tb/tb_tpu_uart_controller.sv
// Directed bench for tpu_uart_controller at 10 clocks per bit: drives serial
// commands, decodes serial replies and counts output strobes.
module tb_tpu_uart_controller;

  localparam int CPB = 10;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               uart_rx = 1'b1;
  logic               uart_tx;
  logic               wf_push_col0;
  logic               wf_push_col1;
  logic [7:0]         wf_data_in;
  logic               wf_reset;
  logic               init_act_valid;
  logic [15:0]        init_act_data;
  logic               start_mlp;
  logic               weights_ready;
  logic [3:0]         mlp_state = 4'd0;
  logic [4:0]         mlp_cycle_cnt = 5'd0;
  logic signed [31:0] mlp_acc0 = 32'sd0;
  logic signed [31:0] mlp_acc1 = 32'sd0;
  logic [3:0]         dbg_state;
  logic [7:0]         dbg_cmd_reg;
  logic [2:0]         dbg_byte_count;
  logic [1:0]         dbg_resp_byte_idx;
  logic               dbg_tx_valid;
  logic               dbg_tx_ready;
  logic               dbg_rx_valid;
  logic [7:0]         dbg_rx_data;
  logic               dbg_weights_ready;
  logic               dbg_start_mlp;

  always #5 clk = ~clk;

  tpu_uart_controller #(
    .CLOCK_FREQ(1_000_000),
    .BAUD_RATE (100_000)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .uart_rx           (uart_rx),
    .uart_tx           (uart_tx),
    .wf_push_col0      (wf_push_col0),
    .wf_push_col1      (wf_push_col1),
    .wf_data_in        (wf_data_in),
    .wf_reset          (wf_reset),
    .init_act_valid    (init_act_valid),
    .init_act_data     (init_act_data),
    .start_mlp         (start_mlp),
    .weights_ready     (weights_ready),
    .mlp_state         (mlp_state),
    .mlp_cycle_cnt     (mlp_cycle_cnt),
    .mlp_acc0          (mlp_acc0),
    .mlp_acc1          (mlp_acc1),
    .dbg_state         (dbg_state),
    .dbg_cmd_reg       (dbg_cmd_reg),
    .dbg_byte_count    (dbg_byte_count),
    .dbg_resp_byte_idx (dbg_resp_byte_idx),
    .dbg_tx_valid      (dbg_tx_valid),
    .dbg_tx_ready      (dbg_tx_ready),
    .dbg_rx_valid      (dbg_rx_valid),
    .dbg_rx_data       (dbg_rx_data),
    .dbg_weights_ready (dbg_weights_ready),
    .dbg_start_mlp     (dbg_start_mlp)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] col0_q[$];
  logic [7:0] col1_q[$];
  logic [7:0] tx_q[$];
  int         act_cnt     = 0;
  int         start_cnt   = 0;
  int         wfr_cnt     = 0;
  int         overlap_cnt = 0;
  logic [15:0] last_act   = 16'h0;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (wf_push_col0) col0_q.push_back(wf_data_in);
    if (wf_push_col1) col1_q.push_back(wf_data_in);
    if (init_act_valid) begin
      act_cnt  <= act_cnt + 1;
      last_act <= init_act_data;
    end
    if (start_mlp) start_cnt <= start_cnt + 1;
    if (wf_reset) wfr_cnt <= wfr_cnt + 1;
    if ((int'(wf_push_col0) + int'(wf_push_col1) + int'(init_act_valid) +
         int'(start_mlp) + int'(wf_reset)) > 1) overlap_cnt <= overlap_cnt + 1;
  end

  // Serial reply decoder.
  initial begin : tx_decoder
    logic [7:0] b;
    b = 8'h00;
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0 && rst === 1'b1) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        tx_q.push_back(b);
      end
    end
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", n_pass, n_total);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic wait_tx(input int want, input string tag);
    int waited;
    waited = 0;
    while (tx_q.size() < want && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    chk(tag, 32'(tx_q.size() >= want), 32'd1);
  endtask

  function automatic logic [31:0] q8(input logic [7:0] q[$], input int idx);
    return (idx < q.size()) ? 32'(q[idx]) : 32'hFFFF_FFFF;
  endfunction

  initial begin : main
    int base_c0;
    int base_c1;
    int base_tx;
    int base_act;
    int base_st;
    int base_wfr;
    logic [7:0] zero_byte;

    // Reset state while rst is held low.
    repeat (5) @(negedge clk);
    chk("rst_uart_tx", 32'(uart_tx), 32'd1);
    chk("rst_weights_ready", 32'(weights_ready), 32'd0);
    chk("rst_wf_data_in", 32'(wf_data_in), 32'd0);
    chk("rst_init_act_data", 32'(init_act_data), 32'd0);
    chk("rst_start_mlp", 32'(start_mlp), 32'd0);
    chk("rst_init_act_valid", 32'(init_act_valid), 32'd0);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    // WRITE_WEIGHTS
    send_frame(8'h01, 1'b1);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    chk("ww_not_ready_before_last", 32'(weights_ready), 32'd0);
    send_frame(8'h44, 1'b1);
    repeat (5) @(negedge clk);
    chk("ww_col0_count", 32'(col0_q.size()), 32'd2);
    chk("ww_col0_b0", q8(col0_q, 0), 32'h11);
    chk("ww_col0_b1", q8(col0_q, 1), 32'h22);
    chk("ww_col1_count", 32'(col1_q.size()), 32'd2);
    chk("ww_col1_b0", q8(col1_q, 0), 32'h33);
    chk("ww_col1_b1", q8(col1_q, 1), 32'h44);
    chk("ww_weights_ready", 32'(weights_ready), 32'd1);
    chk("ww_data_hold", 32'(wf_data_in), 32'h44);

    // WRITE_ACT then RUN
    base_act = act_cnt;
    send_frame(8'h02, 1'b1);
    send_frame(8'h34, 1'b1);
    send_frame(8'h12, 1'b1);
    repeat (5) @(negedge clk);
    chk("act_valid_pulses", 32'(act_cnt - base_act), 32'd1);
    chk("act_strobe_data", 32'(last_act), 32'h1234);
    chk("act_data_hold", 32'(init_act_data), 32'h1234);
    base_st = start_cnt;
    send_frame(8'h03, 1'b1);
    repeat (5) @(negedge clk);
    chk("run_start_pulses", 32'(start_cnt - base_st), 32'd1);

    // READ_ACC0; accumulator changes right after the command to check the snapshot
    mlp_acc0 = 32'hDEADBEEF;
    base_tx = tx_q.size();
    send_frame(8'h05, 1'b1);
    mlp_acc0 = 32'h0;
    wait_tx(base_tx + 4, "acc0_reply_arrived");
    chk("acc0_b0", q8(tx_q, base_tx + 0), 32'hEF);
    chk("acc0_b1", q8(tx_q, base_tx + 1), 32'hBE);
    chk("acc0_b2", q8(tx_q, base_tx + 2), 32'hAD);
    chk("acc0_b3", q8(tx_q, base_tx + 3), 32'hDE);
    repeat (30) @(negedge clk);

    // STATUS
    mlp_state = 4'd5;
    mlp_cycle_cnt = 5'd17;
    base_tx = tx_q.size();
    send_frame(8'h04, 1'b1);
    wait_tx(base_tx + 2, "status_reply_arrived");
    chk("status_b0", q8(tx_q, base_tx + 0), 32'h05);
    chk("status_b1", q8(tx_q, base_tx + 1), 32'h11);
    repeat (30) @(negedge clk);

    // READ_ACC1
    mlp_acc1 = 32'sh8000_0001;
    base_tx = tx_q.size();
    send_frame(8'h06, 1'b1);
    wait_tx(base_tx + 4, "acc1_reply_arrived");
    chk("acc1_b0", q8(tx_q, base_tx + 0), 32'h01);
    chk("acc1_b3", q8(tx_q, base_tx + 3), 32'h80);
    repeat (150) @(negedge clk);
    chk("acc1_no_extra_bytes", 32'(tx_q.size() - base_tx), 32'd4);

    // Three-cycle glitch must not start a frame that swallows the next command
    base_st = start_cnt;
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(8'h03, 1'b1);
    repeat (5) @(negedge clk);
    chk("glitch_then_run", 32'(start_cnt - base_st), 32'd1);

    // Bad stop bit discards the byte; FSM still accepts a following command
    base_tx = tx_q.size();
    send_frame(8'h05, 1'b0);
    repeat (300) @(negedge clk);
    chk("badstop_no_reply", 32'(tx_q.size() - base_tx), 32'd0);
    base_st = start_cnt;
    send_frame(8'h03, 1'b1);
    repeat (5) @(negedge clk);
    chk("badstop_then_run", 32'(start_cnt - base_st), 32'd1);

    // Unknown opcode is ignored
    base_st = start_cnt;
    send_frame(8'hFF, 1'b1);
    send_frame(8'h03, 1'b1);
    repeat (5) @(negedge clk);
    chk("unknown_then_run", 32'(start_cnt - base_st), 32'd1);
    chk("unknown_no_reply", 32'(tx_q.size() - base_tx), 32'd0);

    // Reset in the middle of a WRITE_WEIGHTS payload byte
    send_frame(8'h01, 1'b1);
    send_frame(8'hAA, 1'b1);
    zero_byte = 8'h00;
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = zero_byte[i];
      if (i == 2) begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_weights_ready", 32'(weights_ready), 32'd0);
        chk("midrst_uart_tx", 32'(uart_tx), 32'd1);
        chk("midrst_wf_data_in", 32'(wf_data_in), 32'd0);
        chk("midrst_init_act_data", 32'(init_act_data), 32'd0);
        rst = 1'b1;
        repeat (CPB - 5) @(negedge clk);
      end else begin
        repeat (CPB) @(negedge clk);
      end
    end
    uart_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    base_c0  = col0_q.size();
    base_c1  = col1_q.size();
    base_wfr = wfr_cnt;
    send_frame(8'h07, 1'b1);
    repeat (5) @(negedge clk);
    chk("postrst_clear_pulses", 32'(wfr_cnt - base_wfr), 32'd1);
    chk("postrst_weights_ready", 32'(weights_ready), 32'd0);
    chk("postrst_no_pushes", 32'((col0_q.size() - base_c0) + (col1_q.size() - base_c1)), 32'd0);

    // Reload weights then clear them
    send_frame(8'h01, 1'b1);
    send_frame(8'h55, 1'b1);
    send_frame(8'h66, 1'b1);
    send_frame(8'h77, 1'b1);
    send_frame(8'h88, 1'b1);
    repeat (5) @(negedge clk);
    chk("reload_weights_ready", 32'(weights_ready), 32'd1);
    chk("reload_col1_last", q8(col1_q, col1_q.size() - 1), 32'h88);
    base_wfr = wfr_cnt;
    send_frame(8'h07, 1'b1);
    repeat (5) @(negedge clk);
    chk("clear_pulses", 32'(wfr_cnt - base_wfr), 32'd1);
    chk("clear_weights_ready", 32'(weights_ready), 32'd0);

    chk("strobes_exclusive", 32'(overlap_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
